// File: rtl/vrf_read_pipe_multi.sv
// vrf_read_pipe_multi: round-robin arbitration of NCH read channels onto one VRF read port, with per-channel result FIFOs
// Ports: req_* per-channel requests (req_ready = accepted this cycle); vrfReadRequest_* arbitrated VRF request;
//        vrfReadResult returns READ_LATENCY cycles after fire; deq_* per-channel FWFT result FIFOs; overflow_err sticky.
module vrf_read_pipe_multi #(
  parameter int NCH          = 4,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2,
  parameter int QDEPTH       = 4,
  parameter int VS_W         = 5,
  parameter int OFF_W        = 5,
  parameter int SRC_W        = 2,
  parameter int IDX_W        = 3
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH*VS_W-1:0]   req_vs,
  input  logic [NCH*OFF_W-1:0]  req_offset,
  input  logic [NCH*SRC_W-1:0]  req_source,
  input  logic [NCH*IDX_W-1:0]  req_idx,
  input  logic                  vrfReadRequest_ready,
  output logic                  vrfReadRequest_valid,
  output logic [VS_W-1:0]       vrfReadRequest_bits_vs,
  output logic [OFF_W-1:0]      vrfReadRequest_bits_offset,
  output logic [SRC_W-1:0]      vrfReadRequest_bits_readSource,
  output logic [IDX_W-1:0]      vrfReadRequest_bits_instructionIndex,
  input  logic [DATA_W-1:0]     vrfReadResult,
  input  logic [NCH-1:0]        deq_ready,
  output logic [NCH-1:0]        deq_valid,
  output logic [NCH*DATA_W-1:0] deq_data,
  output logic                  overflow_err
);
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int AW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  localparam int L  = READ_LATENCY;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (int'(p) == QDEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  logic [PW-1:0]     ptr_q, ptr_d, gnt_id;
  logic [NCH-1:0]    eligible, push, pop, wen;
  logic              fire;
  logic [L-1:0]      tag_v_q, tag_v_d;
  logic [PW-1:0]     tag_id_q [L];
  logic [PW-1:0]     tag_id_d [L];
  logic [CW-1:0]     credit_q [NCH];
  logic [CW-1:0]     credit_d [NCH];
  logic [CW-1:0]     cnt_q [NCH];
  logic [CW-1:0]     cnt_d [NCH];
  logic [AW-1:0]     rd_q [NCH];
  logic [AW-1:0]     rd_d [NCH];
  logic [AW-1:0]     wr_q [NCH];
  logic [AW-1:0]     wr_d [NCH];
  logic [DATA_W-1:0] mem_q [NCH][QDEPTH];
  logic              overflow_q, overflow_d;

  // Credits count FIFO words plus reads in flight, so a granted read always has a slot waiting for it.
  always_comb begin
    for (int c = 0; c < NCH; c++) eligible[c] = req_valid[c] && (credit_q[c] < CW'(QDEPTH));
  end

  // Scan downward so the lowest offset from ptr_q wins.
  always_comb begin
    gnt_id = ptr_q;
    for (int i = NCH - 1; i >= 0; i--)
      if (eligible[(int'(ptr_q) + i) % NCH]) gnt_id = PW'((int'(ptr_q) + i) % NCH);
  end

  assign vrfReadRequest_valid                = |eligible;
  assign fire                                = vrfReadRequest_valid && vrfReadRequest_ready;
  assign req_ready                           = fire ? (NCH'(1) << gnt_id) : '0;
  assign vrfReadRequest_bits_vs              = vrfReadRequest_valid ? req_vs[int'(gnt_id)*VS_W +: VS_W] : '0;
  assign vrfReadRequest_bits_offset          = vrfReadRequest_valid ? req_offset[int'(gnt_id)*OFF_W +: OFF_W] : '0;
  assign vrfReadRequest_bits_readSource      = vrfReadRequest_valid ? req_source[int'(gnt_id)*SRC_W +: SRC_W] : '0;
  assign vrfReadRequest_bits_instructionIndex = vrfReadRequest_valid ? req_idx[int'(gnt_id)*IDX_W +: IDX_W] : '0;
  assign overflow_err                        = overflow_q;

  always_comb begin
    ptr_d = fire ? ((int'(gnt_id) == NCH - 1) ? '0 : gnt_id + 1'b1) : ptr_q;
    tag_v_d[0]  = fire;
    tag_id_d[0] = gnt_id;
    for (int i = 1; i < L; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  // A full FIFO still accepts a push when it pops in the same cycle; only a push without room is dropped and flagged.
  always_comb begin
    overflow_d = overflow_q;
    deq_data   = '0;
    for (int c = 0; c < NCH; c++) begin
      push[c]      = tag_v_q[L-1] && (tag_id_q[L-1] == PW'(c));
      deq_valid[c] = cnt_q[c] != '0;
      pop[c]       = deq_ready[c] && deq_valid[c];
      wen[c]       = push[c] && (cnt_q[c] != CW'(QDEPTH) || pop[c]);
      if (push[c] && !wen[c]) overflow_d = 1'b1;
      deq_data[c*DATA_W +: DATA_W] = mem_q[c][rd_q[c]];
      rd_d[c]     = pop[c] ? inc(rd_q[c]) : rd_q[c];
      wr_d[c]     = wen[c] ? inc(wr_q[c]) : wr_q[c];
      cnt_d[c]    = cnt_q[c] + CW'(wen[c]) - CW'(pop[c]);
      credit_d[c] = credit_q[c] + CW'(req_ready[c]) - CW'(pop[c]);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      tag_v_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < L; i++) tag_id_q[i] <= '0;
      for (int c = 0; c < NCH; c++) begin
        credit_q[c] <= '0;
        cnt_q[c]    <= '0;
        rd_q[c]     <= '0;
        wr_q[c]     <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      tag_v_q    <= tag_v_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < L; i++) tag_id_q[i] <= tag_id_d[i];
      for (int c = 0; c < NCH; c++) begin
        credit_q[c] <= credit_d[c];
        cnt_q[c]    <= cnt_d[c];
        rd_q[c]     <= rd_d[c];
        wr_q[c]     <= wr_d[c];
      end
    end
  end

  // Storage needs no reset: occupancy counters decide what is visible.
  always_ff @(posedge clock) begin
    for (int c = 0; c < NCH; c++)
      if (wen[c]) mem_q[c][wr_q[c]] <= vrfReadResult;
  end
endmodule

// File: tb/tb_vrf_read_pipe_multi.sv
// tb_vrf_read_pipe_multi: randomized and directed checks of vrf_read_pipe_multi against a queue-based reference model
module tb_vrf_read_pipe_multi;
  localparam int NCH = 4, DW = 32, L = 2, QD = 4, VS_W = 5, OFF_W = 5, SRC_W = 2, IDX_W = 3;

  logic                 clock = 0, rst_n = 0;
  logic [NCH-1:0]       req_valid = '0, req_ready, deq_ready = '0, deq_valid;
  logic [NCH*VS_W-1:0]  req_vs = '0;
  logic [NCH*OFF_W-1:0] req_offset = '0;
  logic [NCH*SRC_W-1:0] req_source = '0;
  logic [NCH*IDX_W-1:0] req_idx = '0;
  logic                 vrfReadRequest_ready = 0, vrfReadRequest_valid, overflow_err;
  logic [VS_W-1:0]      bits_vs;
  logic [OFF_W-1:0]     bits_off;
  logic [SRC_W-1:0]     bits_src;
  logic [IDX_W-1:0]     bits_idx;
  logic [DW-1:0]        vrfReadResult = '0;
  logic [NCH*DW-1:0]    deq_data;

  always #5 clock = ~clock;

  vrf_read_pipe_multi #(.NCH(NCH), .DATA_W(DW), .READ_LATENCY(L), .QDEPTH(QD),
    .VS_W(VS_W), .OFF_W(OFF_W), .SRC_W(SRC_W), .IDX_W(IDX_W)) dut (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vs(req_vs), .req_offset(req_offset), .req_source(req_source), .req_idx(req_idx),
    .vrfReadRequest_ready(vrfReadRequest_ready), .vrfReadRequest_valid(vrfReadRequest_valid),
    .vrfReadRequest_bits_vs(bits_vs), .vrfReadRequest_bits_offset(bits_off),
    .vrfReadRequest_bits_readSource(bits_src), .vrfReadRequest_bits_instructionIndex(bits_idx),
    .vrfReadResult(vrfReadResult), .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_data(deq_data), .overflow_err(overflow_err));

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { int ch; int due; } rd_t;
  logic [DW-1:0] mq [NCH][$];
  rd_t infl[$];
  int ptr = 0, cyc = 0, fired = -1;

  function automatic int credit(input int c);
    int n = mq[c].size();
    foreach (infl[k]) if (infl[k].ch == c) n++;
    return n;
  endfunction

  task automatic step(input logic [NCH-1:0] rv, input logic rr, input logic [NCH-1:0] dr, input logic [DW-1:0] res);
    int g;
    @(negedge clock);
    req_valid = rv; vrfReadRequest_ready = rr; deq_ready = dr; vrfReadResult = res;
    req_vs = (NCH*VS_W)'($urandom); req_offset = (NCH*OFF_W)'($urandom);
    req_source = (NCH*SRC_W)'($urandom); req_idx = (NCH*IDX_W)'($urandom);
    #1;
    g = -1;
    for (int i = 0; i < NCH; i++) begin
      int c = (ptr + i) % NCH;
      if (g < 0 && rv[c] && credit(c) < QD) g = c;
    end
    check("vrf_valid", vrfReadRequest_valid, g >= 0);
    check("req_ready", req_ready, (g >= 0 && rr) ? (64'd1 << g) : 64'd0);
    if (g >= 0)
      check("bits", {bits_vs, bits_off, bits_src, bits_idx},
            {req_vs[g*VS_W +: VS_W], req_offset[g*OFF_W +: OFF_W], req_source[g*SRC_W +: SRC_W], req_idx[g*IDX_W +: IDX_W]});
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("deq_valid%0d", c), deq_valid[c], mq[c].size() > 0);
      if (mq[c].size() > 0) check($sformatf("deq_data%0d", c), deq_data[c*DW +: DW], mq[c][0]);
    end
    check("overflow", overflow_err, 0);
    fired = -1;
    for (int c = 0; c < NCH; c++) if (req_ready[c]) fired = c;
    for (int c = 0; c < NCH; c++) if (dr[c] && mq[c].size() > 0) void'(mq[c].pop_front());
    if (infl.size() > 0 && infl[0].due == cyc) begin
      mq[infl[0].ch].push_back(res);
      void'(infl.pop_front());
    end
    if (g >= 0 && rr) begin
      infl.push_back('{g, cyc + L});
      ptr = (g + 1) % NCH;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 0; req_valid = '0; vrfReadRequest_ready = 0; deq_ready = '0;
    #1;
    check("rst_deq_valid", deq_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_vrf_valid", vrfReadRequest_valid, 0);
    check("rst_overflow", overflow_err, 0);
    for (int c = 0; c < NCH; c++) mq[c].delete();
    infl.delete();
    ptr = 0;
    repeat (2) @(negedge clock);
    rst_n = 1;
  endtask

  initial begin
    int nf;
    do_reset();
    repeat (3) step('0, 1, '0, $urandom);
    step(4'b0100, 1, '1, $urandom);
    check("single_fire", fired, 2);
    step('0, 1, '1, $urandom);
    step('0, 1, '1, 32'hDEADBEEF);
    step('0, 1, '0, $urandom);
    check("single_valid", deq_valid[2], 1);
    check("single_data", deq_data[2*DW +: DW], 32'hDEADBEEF);
    step('0, 1, '1, $urandom);
    for (int k = 0; k < 16; k++) begin
      step('1, 1, '1, $urandom);
      check("rr_grant", fired, (3 + k) % NCH);
    end
    repeat (4) step('0, 1, '1, $urandom);
    nf = 0;
    for (int k = 0; k < 10; k++) begin
      step(4'b0001, 1, '0, $urandom);
      nf += (fired == 0);
    end
    check("bp_fires", nf, QD);
    check("bp_ready_low", req_ready[0], 0);
    step(4'b0001, 1, 4'b0001, $urandom);
    nf = 0;
    for (int k = 0; k < 6; k++) begin
      step(4'b0001, 1, '0, $urandom);
      nf += (fired == 0);
    end
    check("bp_refill", nf, 1);
    repeat (12) step(4'b0001, 1, 4'b0001, $urandom);
    repeat (8) step('0, 1, '1, $urandom);
    for (int k = 0; k < 40; k++) step(4'b1010, k % 2 == 0, 4'($urandom), $urandom);
    repeat (8) step('0, 1, '1, $urandom);
    for (int k = 0; k < 600; k++) step(4'($urandom), ($urandom % 4) != 0, 4'($urandom), $urandom);
    repeat (8) step('0, 1, '1, $urandom);
    repeat (3) step('1, 1, '0, $urandom);
    do_reset();
    for (int k = 0; k < 6; k++) step('0, 1, '0, $urandom);
    check("post_rst_empty", deq_valid, 0);
    for (int k = 0; k < 100; k++) step(4'($urandom), ($urandom % 3) != 0, 4'($urandom), $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
